// File: rtl/noc_pkt_pkg.sv
// Shared definitions for the serial NoC packetizer and anything that needs
// to build or decode its flits (e.g. a depacketizer golden model).
//   - flit control-bit offsets, counted down from the flit MSB
//   - calc_num_flits(): number of flits needed to carry a payload word
//   - state_t: packetizer FSM states
package noc_pkt_pkg;

  // Offsets from the flit MSB: [FW-1] valid, [FW-2] head, [FW-3] tail.
  localparam int VALID_OFS  = 0;
  localparam int HEAD_OFS   = 1;
  localparam int TAIL_OFS   = 2;
  localparam int CTRL_BITS  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // The head flit carries the destination and therefore less payload than
  // body/tail flits; everything that does not fit in the head is spread over
  // BODY_PL-wide follow-on flits.
  function automatic int calc_num_flits(input int width_in, input int flit_width,
                                        input int addr_w, input int vc_w);
    int head_pl;
    int body_pl;
    head_pl = flit_width - CTRL_BITS - addr_w - vc_w;
    body_pl = flit_width - CTRL_BITS - vc_w;
    if (width_in <= head_pl) return 1;
    return 1 + (width_in - head_pl + body_pl - 1) / body_pl;
  endfunction

endpackage

// File: rtl/flit_slicer.sv
// Combinational flit builder: selects flit number idx of a packet carrying
// (data, dst, vc) and formats it as
//   head flit : {valid, head=1, tail, vc, dst, payload[HEAD_PL]}
//   body/tail : {valid, head=0, tail, vc, payload[BODY_PL]}
// Payload is taken MSB first, left-aligned in its field, zero-padded below.
// Ports:
//   data [WIDTH_IN]         payload word
//   dst  [ADDRESS_WIDTH]    destination router
//   vc   [VC_ADDRESS_WIDTH] virtual channel
//   idx  [CNT_W]            flit index within the packet (0 = head)
//   flit [FLIT_WIDTH]       formatted flit
module flit_slicer
  import noc_pkt_pkg::*;
#(
  parameter  int ADDRESS_WIDTH    = 4,
  parameter  int VC_ADDRESS_WIDTH = 1,
  parameter  int WIDTH_IN         = 20,
  parameter  int FLIT_WIDTH       = 12,
  localparam int HEAD_PL   = FLIT_WIDTH - CTRL_BITS - ADDRESS_WIDTH - VC_ADDRESS_WIDTH,
  localparam int BODY_PL   = FLIT_WIDTH - CTRL_BITS - VC_ADDRESS_WIDTH,
  localparam int NUM_FLITS = calc_num_flits(WIDTH_IN, FLIT_WIDTH, ADDRESS_WIDTH,
                                            VC_ADDRESS_WIDTH),
  localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1
) (
  input  logic [WIDTH_IN-1:0]         data,
  input  logic [ADDRESS_WIDTH-1:0]    dst,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc,
  input  logic [CNT_W-1:0]            idx,
  output logic [FLIT_WIDTH-1:0]       flit
);

  // The word is left-aligned in a vector with at least BODY_PL spare zero
  // bits at the bottom, so any flit's slice (including the padded last one,
  // or a body slice when NUM_FLITS is 1) stays in range.
  localparam int EXT_W = HEAD_PL + NUM_FLITS * BODY_PL;

  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] shifted;
  int               shift_amt;
  logic             last;

  always_comb begin
    ext       = {data, {(EXT_W - WIDTH_IN){1'b0}}};
    shifted   = ext;
    shift_amt = 0;
    last      = (idx == CNT_W'(NUM_FLITS - 1));
    flit      = '0;
    flit[FLIT_WIDTH-1-VALID_OFS] = 1'b1;
    flit[FLIT_WIDTH-1-HEAD_OFS]  = (idx == '0);
    flit[FLIT_WIDTH-1-TAIL_OFS]  = last;
    flit[FLIT_WIDTH-1-CTRL_BITS -: VC_ADDRESS_WIDTH] = vc;
    if (idx == '0) begin
      flit[FLIT_WIDTH-1-CTRL_BITS-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH] = dst;
      flit[HEAD_PL-1:0] = ext[EXT_W-1 -: HEAD_PL];
    end else begin
      // Skip the head payload and the preceding body flits.
      shift_amt         = HEAD_PL + (int'(idx) - 1) * BODY_PL;
      shifted           = ext << shift_amt;
      flit[BODY_PL-1:0] = shifted[EXT_W-1 -: BODY_PL];
    end
  end

endmodule

// File: rtl/packetizer_serial.sv
// Serial packetizer: accepts one (data, dst, vc) word and streams it as
// NUM_FLITS flits, one per cycle, onto a FLIT_WIDTH-wide injection port.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   data_in/dst_in/vc_in, valid_in, ready_out   upstream word interface
//   data_out, valid_out, ready_in               downstream flit interface
//   busy              high while a packet is in flight
//   fsm_state         current FSM state (observation only)
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high. valid is never withdrawn and its data never changes until the
// transfer occurs. ready_out is combinational from ready_in, so a new word
// can be taken on the same edge as the previous packet's tail.
module packetizer_serial
  import noc_pkt_pkg::*;
#(
  parameter  int ADDRESS_WIDTH    = 4,
  parameter  int VC_ADDRESS_WIDTH = 1,
  parameter  int WIDTH_IN         = 20,
  parameter  int FLIT_WIDTH       = 12,
  localparam int NUM_FLITS = calc_num_flits(WIDTH_IN, FLIT_WIDTH, ADDRESS_WIDTH,
                                            VC_ADDRESS_WIDTH),
  localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_IN-1:0]         data_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [FLIT_WIDTH-1:0]       data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        busy,
  output state_t                      fsm_state
);

  logic [WIDTH_IN-1:0]         data_q;
  logic [ADDRESS_WIDTH-1:0]    dst_q;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;
  logic [CNT_W-1:0]            idx;

  logic [WIDTH_IN-1:0]         sel_data;
  logic [ADDRESS_WIDTH-1:0]    sel_dst;
  logic [VC_ADDRESS_WIDTH-1:0] sel_vc;
  logic [CNT_W-1:0]            sel_idx;
  logic [FLIT_WIDTH-1:0]       next_flit;
  logic                        last;
  logic                        accept;

  assign last      = (idx == CNT_W'(NUM_FLITS - 1));
  assign ready_out = (fsm_state == IDLE) | ((fsm_state == SEND) & last & ready_in);
  assign accept    = valid_in & ready_out;

  // One slicer serves both cases: on accept it formats the head of the
  // incoming word, otherwise the next flit of the latched word.
  always_comb begin
    sel_data = data_q;
    sel_dst  = dst_q;
    sel_vc   = vc_q;
    sel_idx  = idx + CNT_W'(1);
    if (accept) begin
      sel_data = data_in;
      sel_dst  = dst_in;
      sel_vc   = vc_in;
      sel_idx  = '0;
    end
  end

  flit_slicer #(
    .ADDRESS_WIDTH    (ADDRESS_WIDTH),
    .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH),
    .WIDTH_IN         (WIDTH_IN),
    .FLIT_WIDTH       (FLIT_WIDTH)
  ) u_slicer (
    .data (sel_data),
    .dst  (sel_dst),
    .vc   (sel_vc),
    .idx  (sel_idx),
    .flit (next_flit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_state <= IDLE;
      valid_out <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
      idx       <= '0;
      data_q    <= '0;
      dst_q     <= '0;
      vc_q      <= '0;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (accept) begin
            data_q    <= data_in;
            dst_q     <= dst_in;
            vc_q      <= vc_in;
            idx       <= '0;
            data_out  <= next_flit;
            valid_out <= 1'b1;
            busy      <= 1'b1;
            fsm_state <= SEND;
          end
        end
        SEND: begin
          // valid_out is always high here, so ready_in alone is the handshake.
          if (ready_in) begin
            if (!last) begin
              idx      <= sel_idx;
              data_out <= next_flit;
            end else if (accept) begin
              // Tail leaves and the next head follows with no idle cycle.
              data_q   <= data_in;
              dst_q    <= dst_in;
              vc_q     <= vc_in;
              idx      <= '0;
              data_out <= next_flit;
            end else begin
              idx       <= '0;
              data_out  <= '0;
              valid_out <= 1'b0;
              busy      <= 1'b0;
              fsm_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packetizer_serial.sv
// Bench for packetizer_serial: default (20-bit, 3-flit) instance driven with
// directed and random traffic, plus 16-bit and 4-bit instances for the
// padding and single-flit cases. Flits are predicted by model_flit(), which
// derives each flit bit-by-bit from the flit format rules.
module tb_packetizer_serial;
  import noc_pkt_pkg::*;

  localparam int HPL = 4;
  localparam int BPL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance (WIDTH_IN=20)
  logic [19:0] data_in = '0;
  logic [3:0]  dst_in = '0;
  logic        vc_in = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [11:0] data_out;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic        busy;
  state_t      fsm_state;

  packetizer_serial dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dst_in(dst_in), .vc_in(vc_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .busy(busy), .fsm_state(fsm_state)
  );

  // WIDTH_IN=16 instance
  logic [15:0] data16 = '0;
  logic [3:0]  dst16 = '0;
  logic        vc16 = 1'b0;
  logic        valid16 = 1'b0;
  logic        ready_out16;
  logic [11:0] data_out16;
  logic        valid_out16;
  logic        busy16;
  state_t      state16;

  packetizer_serial #(.WIDTH_IN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .data_in(data16), .dst_in(dst16), .vc_in(vc16),
    .valid_in(valid16), .ready_out(ready_out16), .data_out(data_out16),
    .valid_out(valid_out16), .ready_in(1'b1), .busy(busy16), .fsm_state(state16)
  );

  // WIDTH_IN=4 instance (single-flit packets)
  logic [3:0]  data4 = '0;
  logic [3:0]  dst4 = '0;
  logic        vc4 = 1'b0;
  logic        valid4 = 1'b0;
  logic        ready_out4;
  logic [11:0] data_out4;
  logic        valid_out4;
  logic        busy4;
  state_t      state4;

  packetizer_serial #(.WIDTH_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data4), .dst_in(dst4), .vc_in(vc4),
    .valid_in(valid4), .ready_out(ready_out4), .data_out(data_out4),
    .valid_out(valid_out4), .ready_in(1'b1), .busy(busy4), .fsm_state(state4)
  );

  // ---------------- reference model ----------------
  function automatic int model_nf(input int w);
    return (w <= HPL) ? 1 : 1 + (w - HPL + BPL - 1) / BPL;
  endfunction

  function automatic logic [11:0] model_flit(input logic [31:0] d, input int w,
                                             input logic [3:0] ds, input logic v,
                                             input int k);
    logic [11:0] f;
    int pos;
    int pl;
    int top;
    f     = '0;
    f[11] = 1'b1;
    f[10] = (k == 0);
    f[9]  = (k == model_nf(w) - 1);
    f[8]  = v;
    if (k == 0) begin
      f[7:4] = ds;
      pos = w - 1;
      pl  = HPL;
      top = 3;
    end else begin
      pos = w - 1 - HPL - (k - 1) * BPL;
      pl  = BPL;
      top = 7;
    end
    for (int j = 0; j < pl; j++)
      if (pos - j >= 0) f[top-j] = d[pos-j];
    return f;
  endfunction

  // ---------------- scoreboard on the default instance ----------------
  logic [11:0] exp_q[$];
  int          hs_cyc[$];
  logic [11:0] exp_flit;

  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected_flit got=%h want=none", data_out);
      end else begin
        exp_flit = exp_q.pop_front();
        if (data_out !== exp_flit) begin
          bad++;
          $display("FAIL mon_flit got=%h want=%h", data_out, exp_flit);
        end
      end
      hs_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send_word(input logic [19:0] d, input logic [3:0] ds, input logic v);
    int guard;
    data_in  = d;
    dst_in   = ds;
    vc_in    = v;
    valid_in = 1'b1;
    guard    = 0;
    @(negedge clk);
    while (!ready_out && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_out) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=ready_out=0 want=1");
    end else begin
      for (int k = 0; k < 3; k++) exp_q.push_back(model_flit(32'(d), 20, ds, v, k));
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d left want=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({valid_out, data_out, busy, ready_out, fsm_state} !== {1'b0, 12'h000, 1'b0, 1'b1, IDLE}) begin
      bad++;
      $display("FAIL reset_state got=v%b d%h b%b r%b s%b want=v0 d000 b0 r1 s0",
               valid_out, data_out, busy, ready_out, fsm_state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Idle with valid_in low: nothing appears.
    repeat (5) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet got=v%b b%b want=v0 b0", valid_out, busy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [11:0] want[3];
    want[0] = 12'hD5A;
    want[1] = 12'h9BC;
    want[2] = 12'hBDE;
    ready_in = 1'b1;
    send_word(20'hABCDE, 4'h5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || data_out !== want[k] || busy !== 1'b1) begin
        bad++;
        $display("FAIL basic_flit%0d got=v%b %h b%b want=v1 %h b1", k, valid_out, data_out, busy, want[k]);
      end
    end
    drain();
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle_after got=v%b b%b want=v0 b0", valid_out, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_w16();
    logic [11:0] want[3];
    logic [15:0] d;
    logic [3:0]  ds;
    logic        v;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) begin
        d = 16'h1234; ds = 4'h0; v = 1'b0;
      end else begin
        d = 16'($urandom); ds = 4'($urandom); v = 1'($urandom);
      end
      for (int k = 0; k < 3; k++) want[k] = model_flit(32'(d), 16, ds, v, k);
      if (n == 0) begin
        want[0] = 12'hC01;
        want[1] = 12'h823;
        want[2] = 12'hA40;
      end
      data16 = d; dst16 = ds; vc16 = v; valid16 = 1'b1;
      @(posedge clk);
      #1;
      valid16 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        total++;
        if (valid_out16 !== 1'b1 || data_out16 !== want[k]) begin
          bad++;
          $display("FAIL w16_pkt%0d_flit%0d got=v%b %h want=v1 %h", n, k, valid_out16, data_out16, want[k]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_w4();
    logic [11:0] want;
    logic [3:0]  d;
    logic [3:0]  ds;
    logic        v;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) begin
        d = 4'h3; ds = 4'h2; v = 1'b0;
      end else begin
        d = 4'($urandom); ds = 4'($urandom); v = 1'($urandom);
      end
      want = (n == 0) ? 12'hE23 : model_flit(32'(d), 4, ds, v, 0);
      data4 = d; dst4 = ds; vc4 = v; valid4 = 1'b1;
      @(posedge clk);
      #1;
      valid4 = 1'b0;
      @(negedge clk);
      total++;
      if (valid_out4 !== 1'b1 || data_out4 !== want || data_out4[10:9] !== 2'b11 || ready_out4 !== 1'b1) begin
        bad++;
        $display("FAIL w4_pkt%0d got=v%b %h r%b want=v1 %h r1", n, valid_out4, data_out4, ready_out4, want);
      end
      @(negedge clk);
      total++;
      if (valid_out4 !== 1'b0 || busy4 !== 1'b0) begin
        bad++;
        $display("FAIL w4_idle%0d got=v%b b%b want=v0 b0", n, valid_out4, busy4);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b1;
    send_word(20'hABCDE, 4'h5, 1'b1);
    @(negedge clk);          // head handshake seen by the scoreboard
    @(posedge clk);
    #1;
    ready_in = 1'b0;         // stall on the body flit
    data_in  = 20'h55555;    // must not disturb the packet in flight
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || data_out !== 12'h9BC || ready_out !== 1'b0) begin
        bad++;
        $display("FAIL stall_cycle%0d got=v%b %h r%b want=v1 9bc r0", c, valid_out, data_out, ready_out);
      end
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    ready_in = 1'b1;
    hs_cyc.delete();
    send_word(20'hABCDE, 4'h5, 1'b1);
    send_word(20'h12345, 4'hA, 1'b0);
    drain();
    total++;
    if (hs_cyc.size() != 6) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=6", hs_cyc.size());
    end else if (hs_cyc[5] - hs_cyc[0] != 5) begin
      bad++;
      $display("FAIL b2b_span got=%0d want=5", hs_cyc[5] - hs_cyc[0]);
    end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send_word(20'($urandom), 4'($urandom), 1'($urandom));
        end
        drain();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (!done) ready_in = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_in = 1'b1;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL random_idle_after got=v%b b%b want=v0 b0", valid_out, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit leaked;
    ready_in = 1'b1;
    send_word(20'hABCDE, 4'h5, 1'b1);
    @(negedge clk);          // head handshake
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();          // body and tail must never appear
    @(posedge clk);
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got=v%b b%b want=v0 b0", valid_out, busy);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    leaked = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (valid_out !== 1'b0) leaked = 1'b1;
    end
    total++;
    if (leaked) begin
      bad++;
      $display("FAIL rst_no_tail got=valid_out seen want=none");
    end
    @(posedge clk);
    #1;
    send_word(20'h0F00D, 4'h3, 1'b0);
    @(negedge clk);
    total++;
    if (valid_out !== 1'b1 || data_out !== model_flit(32'h0F00D, 20, 4'h3, 1'b0, 0)) begin
      bad++;
      $display("FAIL rst_fresh_head got=v%b %h want=v1 %h", valid_out, data_out,
               model_flit(32'h0F00D, 20, 4'h3, 1'b0, 0));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w16();
    test_w4();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/packetizer_serial.md
Name: packetizer_serial

Overview:
Sequential successor to the single-cycle three-flit packer. Accepts one data word with destination and VC, splits it into a parametrised number of flits, and streams them one flit per cycle onto a narrow NoC injection port under valid/ready backpressure. Sits between a module's translator output and the router injection port. It replaces the wide-bus packetizers when the link width is FLIT_WIDTH, not the sum of all flit widths.

Parameters:
ADDRESS_WIDTH, 4, router destination address width
VC_ADDRESS_WIDTH, 1, virtual-channel id width
WIDTH_IN, 20, payload word width
FLIT_WIDTH, 12, link flit width; must exceed 3+ADDRESS_WIDTH+VC_ADDRESS_WIDTH
HEAD_PL (derived), FLIT_WIDTH-3-ADDRESS_WIDTH-VC_ADDRESS_WIDTH, payload bits in the head flit
BODY_PL (derived), FLIT_WIDTH-3-VC_ADDRESS_WIDTH, payload bits in each body/tail flit
NUM_FLITS (derived), 1 if WIDTH_IN<=HEAD_PL, else 1+ceil((WIDTH_IN-HEAD_PL)/BODY_PL)
CNT_W (derived), max(1,$clog2(NUM_FLITS)), flit index width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
data_in  input  WIDTH_IN  payload word
dst_in  input  ADDRESS_WIDTH  destination router
vc_in  input  VC_ADDRESS_WIDTH  virtual channel
valid_in  input  1  word valid
ready_out  output  1  word accepted when valid_in&ready_out
data_out  output  FLIT_WIDTH  flit
valid_out  output  1  flit valid
ready_in  input  1  downstream accepts flit when valid_out&ready_in
busy  output  1  packet in flight

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a clk edge: state=IDLE, valid_out=0, data_out=0, busy=0, flit index=0, latched word/dst/vc=0.
- Flit format, MSB first: [FW-1] valid (=valid_out), [FW-2] head, [FW-3] tail, then vc, then dst (head flit only), then payload. Payload is left-aligned. Unused low bits are zero.
- Payload slicing is MSB first. Head takes data[WIDTH_IN-1 -: HEAD_PL]. Body/tail flit k (k>=1) takes the next BODY_PL bits downward. The final flit's partial payload is left-aligned and zero-padded.
- Single-flit packet (NUM_FLITS=1): head=tail=1.
- State machine IDLE/SEND:
  - IDLE: ready_out=1. On accept, latch data/dst/vc, go to SEND, index=0. The head flit is registered onto data_out with valid_out=1 in the next cycle (latency 1).
  - SEND: data_out and valid_out are held stable while valid_out&!ready_in. On handshake with index<NUM_FLITS-1: index++ and the next flit is registered.
  - SEND, on handshake of the last flit: if valid_in is also high (ready_out=1 in this case), accept the new word and present its head the next cycle, with no bubble. Otherwise go to IDLE and deassert valid_out.
- ready_out = (state==IDLE) | (state==SEND & last flit & ready_in). It is combinational from ready_in.
- Sustained throughput is one packet per NUM_FLITS cycles.
- busy=1 in SEND.
- Inputs are sampled only on accept. Changes to data_in/dst_in/vc_in mid-packet have no effect.
- Reset asserted mid-packet drops the packet. valid_out is 0 the cycle after the reset edge, and no partial tail is emitted.
- valid_in=0 in IDLE produces no output. The block never emits a flit without valid_out=1.

Decomposition:
- Shared package noc_pkt_pkg holds:
  - flit bit-position constants (VALID_BIT, HEAD_BIT, TAIL_BIT offsets from MSB);
  - a function computing NUM_FLITS from widths;
  - the state enum {IDLE, SEND}.
- One sub-module, flit_slicer: combinational, selects flit k from the latched word and builds header plus padding. It is reusable by the depacketizer's golden model.
- The FSM, counter and output register stay in the top.

Test Plan:
1. Defaults (3 flits). Accept data 0xABCDE, dst 0x5, vc 1; hold ready_in=1. Required: flits 0xD5A, 0x9BC, 0xBDE on three consecutive cycles starting 1 cycle after accept.
2. WIDTH_IN=16. Send data 0x1234, dst 0, vc 0. Required: flits 0xC01, 0x823, 0xA40; the last flit is zero-padded.
3. WIDTH_IN=4. Send data 0x3, dst 2, vc 0. Required: a single flit 0xE23 with head=tail=1; ready_out=1 again on that handshake cycle.
4. Backpressure. Drop ready_in for 3 cycles during body flit 0x9BC. Required: data_out and valid_out stay stable and ready_out=0; the sequence resumes unchanged.
5. Back-to-back. Keep valid_in high for two words 0xABCDE and 0x12345. Required: 6 flits on 6 consecutive cycles, with the second head immediately after the first tail.
6. Reset mid-packet. Assert rst_n=0 after the head flit handshake. Required: valid_out=0 and busy=0 the next cycle, and no tail is ever emitted for that packet. A fresh packet after reset emits from its head correctly.
